// File: rtl/xor_update_scheduler.sv
// Round-robin update scheduler: picks one lane per cycle (optionally coalescing equal indices)
// and pipelines its bank write mask to the write stage. Optional feature macro: XOR_SCHED_COALESCE_EN.
module xor_update_scheduler #(
  parameter int unsigned NUM_MUL     = 4,
  parameter int unsigned INDEX_WIDTH = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MUL-1:0]             req_valid,
  input  logic [NUM_MUL*INDEX_WIDTH-1:0] req_index,
  output logic [NUM_MUL-1:0]             req_ready,
  input  logic                           hold,
  output logic                           write_reg_0_valid,
  output logic [INDEX_WIDTH-1:0]         write_reg_0_index,
  output logic [INDEX_WIDTH-1:0]         rd_index,
  output logic [NUM_MUL-1:0]             arbiter_result,
  output logic                           busy
);

  localparam int unsigned PTR_W = (NUM_MUL > 1) ? $clog2(NUM_MUL) : 1;

  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   valid0_q, valid0_d;
  logic [INDEX_WIDTH-1:0] wr0_index_q, wr0_index_d;
  logic [INDEX_WIDTH-1:0] rd_index_q, rd_index_d;
  logic [NUM_MUL-1:0]     mask0_q, mask0_d;
  logic                   valid1_q, valid1_d;
  logic [NUM_MUL-1:0]     mask1_q, mask1_d;
  logic                   valid2_q, valid2_d;
  logic [NUM_MUL-1:0]     mask2_q, mask2_d;

  logic                   found;
  logic [PTR_W-1:0]       lane;
  logic [PTR_W-1:0]       winner;
  logic [PTR_W-1:0]       winner_next;
  logic [INDEX_WIDTH-1:0] win_index;
  logic [NUM_MUL-1:0]     issue_mask;
  logic [NUM_MUL-1:0]     ready_c;
  logic                   issue;

  // Round-robin search starting at rr_ptr, then the issue mask for the winner.
  always_comb begin
    found      = 1'b0;
    lane       = '0;
    winner     = '0;
    win_index  = '0;
    issue_mask = '0;
    for (int unsigned k = 0; k < NUM_MUL; k++) begin
      lane = PTR_W'((32'(rr_ptr_q) + k) % NUM_MUL);
      if (!found && req_valid[lane]) begin
        found  = 1'b1;
        winner = lane;
      end
    end
    for (int unsigned i = 0; i < NUM_MUL; i++) begin
      if (PTR_W'(i) == winner) begin
        win_index = req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
      end
    end
    issue_mask[winner] = found;
`ifdef XOR_SCHED_COALESCE_EN
    // Lanes hitting the same entry ride along with the winner.
    for (int unsigned i = 0; i < NUM_MUL; i++) begin
      if (found && req_valid[i] && (req_index[i*INDEX_WIDTH +: INDEX_WIDTH] == win_index)) begin
        issue_mask[i] = 1'b1;
      end
    end
`endif
  end

  assign winner_next = (winner == PTR_W'(NUM_MUL - 1)) ? '0 : winner + PTR_W'(1);
  assign ready_c     = (reset && !hold) ? issue_mask : '0;
  assign issue       = |ready_c;

  // Stage 0 captures new issues; later stages shift unconditionally.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    valid0_d    = 1'b0;
    wr0_index_d = wr0_index_q;
    rd_index_d  = rd_index_q;
    mask0_d     = mask0_q;
    valid1_d    = valid0_q;
    mask1_d     = mask0_q;
    valid2_d    = valid1_q;
    mask2_d     = mask1_q;
    if (issue) begin
      rr_ptr_d    = winner_next;
      valid0_d    = 1'b1;
      wr0_index_d = win_index;
      rd_index_d  = win_index;
      mask0_d     = ready_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      valid0_q    <= 1'b0;
      wr0_index_q <= '0;
      rd_index_q  <= '0;
      mask0_q     <= '0;
      valid1_q    <= 1'b0;
      mask1_q     <= '0;
      valid2_q    <= 1'b0;
      mask2_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      valid0_q    <= valid0_d;
      wr0_index_q <= wr0_index_d;
      rd_index_q  <= rd_index_d;
      mask0_q     <= mask0_d;
      valid1_q    <= valid1_d;
      mask1_q     <= mask1_d;
      valid2_q    <= valid2_d;
      mask2_q     <= mask2_d;
    end
  end

  assign req_ready         = ready_c;
  assign write_reg_0_valid = valid0_q;
  assign write_reg_0_index = wr0_index_q;
  assign rd_index          = rd_index_q;
  assign arbiter_result    = mask2_q & {NUM_MUL{valid2_q}};
  assign busy              = valid0_q | valid1_q | valid2_q;

endmodule

// File: tb/tb_xor_update_scheduler.sv
// Directed self-checking bench for xor_update_scheduler (NUM_MUL=4, INDEX_WIDTH=12).
module tb_xor_update_scheduler;

  localparam int unsigned NM = 4;
  localparam int unsigned IW = 12;

  logic          clk;
  logic          reset;
  logic [NM-1:0] req_valid;
  logic [NM*IW-1:0] req_index;
  logic [NM-1:0] req_ready;
  logic          hold;
  logic          write_reg_0_valid;
  logic [IW-1:0] write_reg_0_index;
  logic [IW-1:0] rd_index;
  logic [NM-1:0] arbiter_result;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference pipeline of issued masks and the last issued index.
  logic [NM-1:0] p0, p1, p2;
  logic [IW-1:0] last_idx;

  xor_update_scheduler #(.NUM_MUL(NM), .INDEX_WIDTH(IW)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_index         (req_index),
    .req_ready         (req_ready),
    .hold              (hold),
    .write_reg_0_valid (write_reg_0_valid),
    .write_reg_0_index (write_reg_0_index),
    .rd_index          (rd_index),
    .arbiter_result    (arbiter_result),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_lane(input int i, input logic [IW-1:0] idx);
    req_valid[i] = 1'b1;
    req_index[i*IW +: IW] = idx;
  endtask

  // One clock edge, then compare registered outputs against the reference pipeline.
  task automatic tick(input logic [NM-1:0] issued, input logic [IW-1:0] idx);
    @(posedge clk);
    #1;
    p2 = p1;
    p1 = p0;
    p0 = issued;
    if (issued != '0) last_idx = idx;
    check("wr0_valid", 32'(write_reg_0_valid), 32'(issued != '0));
    check("wr0_index", 32'(write_reg_0_index), 32'(last_idx));
    check("rd_index", 32'(rd_index), 32'(last_idx));
    check("arbiter_result", 32'(arbiter_result), 32'(p2));
    check("busy", 32'(busy), 32'((p0 | p1 | p2) != '0));
  endtask

  task automatic expect_issue(input logic [NM-1:0] exp_mask, input logic [IW-1:0] exp_idx);
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_mask));
    tick(exp_mask, exp_idx);
    req_valid = req_valid & ~exp_mask;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      check("req_ready_idle", 32'(req_ready), 32'(0));
      tick('0, '0);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    check("req_ready_in_reset", 32'(req_ready), 32'(0));
    repeat (n) @(posedge clk);
    #1;
    p0 = '0; p1 = '0; p2 = '0; last_idx = '0;
    check("rst_wr0_valid", 32'(write_reg_0_valid), 32'(0));
    check("rst_wr0_index", 32'(write_reg_0_index), 32'(0));
    check("rst_rd_index", 32'(rd_index), 32'(0));
    check("rst_arbiter_result", 32'(arbiter_result), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    req_valid = '0;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    hold = 1'b0;
    req_valid = '1;
    req_index = '0;
    p0 = '0; p1 = '0; p2 = '0; last_idx = '0;

    // Reset with requests pending: nothing accepted.
    do_reset(3);
    idle(1);

    // Lanes 0,3 share 0x010, lane 1 at 0x020, pointer at 0.
    set_lane(0, 12'h010);
    set_lane(1, 12'h020);
    set_lane(3, 12'h010);
`ifdef XOR_SCHED_COALESCE_EN
    expect_issue(4'b1001, 12'h010);
    expect_issue(4'b0010, 12'h020);
`else
    expect_issue(4'b0001, 12'h010);
    expect_issue(4'b0010, 12'h020);
    expect_issue(4'b1000, 12'h010);
`endif
    idle(3);

    // Single request on lane 2; mask reaches the write stage two edges later.
    set_lane(2, 12'h05A);
    expect_issue(4'b0100, 12'h05A);
    idle(3);

    // Pointer now 3: lane 3 beats lane 0, then wrap to lane 0.
    set_lane(0, 12'h111);
    set_lane(3, 12'h333);
    expect_issue(4'b1000, 12'h333);
    expect_issue(4'b0001, 12'h111);
    idle(3);

    // Fresh pointer, all lanes requesting continuously with distinct indices.
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      for (int l = 0; l < int'(NM); l++) set_lane(l, 12'(12'h100 + l));
      expect_issue(4'(1 << (i % 4)), 12'(12'h100 + (i % 4)));
    end
    req_valid = '0;
    idle(3);

    // Issue lane 0, then hold for three cycles with lane 1 waiting.
    set_lane(0, 12'h0AA);
    expect_issue(4'b0001, 12'h0AA);
    hold = 1'b1;
    set_lane(1, 12'h0BB);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("req_ready_hold", 32'(req_ready), 32'(0));
      tick('0, '0);
    end
    hold = 1'b0;
    expect_issue(4'b0010, 12'h0BB);
    idle(3);

    // Reset one cycle after an issue: its mask must never appear.
    set_lane(2, 12'h0CC);
    expect_issue(4'b0100, 12'h0CC);
    set_lane(2, 12'h0CC);
    do_reset(1);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_update_scheduler.md
XOR_UPDATE_SCHEDULER -- requirements
Module: xor_update_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_MUL, default 4, meaning the number of requester lanes and of URAM banks.
REQ-002 The block SHALL have parameter INDEX_WIDTH, default 12, meaning the table index width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  input  NUM_MUL  a per-lane update request.
REQ-006 The block SHALL have port req_index  input  NUM_MUL*INDEX_WIDTH  the per-lane target index, with lane i at bits [i*INDEX_WIDTH +: INDEX_WIDTH].
REQ-007 The block SHALL have port req_ready  output  NUM_MUL  the per-lane accept signal; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 The block SHALL have port hold  input  1  downstream stall; no issue occurs while it is high.
REQ-009 The block SHALL have port write_reg_0_valid  output  1  stage-0 issue valid toward the DFU/URAM pipeline.
REQ-010 The block SHALL have port write_reg_0_index  output  INDEX_WIDTH  stage-0 issued index.
REQ-011 The block SHALL have port rd_index  output  INDEX_WIDTH  URAM read address.
REQ-012 The block SHALL have port arbiter_result  output  NUM_MUL  the per-bank write mask, aligned with the write stage.
REQ-013 The block SHALL have port busy  output  1  high while any issue is in flight in stages 0..2.

Function
REQ-014 Winner SHALL be the first lane with req_valid high, searching round-robin from pointer rr_ptr (lane rr_ptr, rr_ptr+1, ... mod NUM_MUL).
REQ-015 Issue mask: the winner, plus every other valid lane whose req_index equals the winner's req_index (coalescing).
REQ-016 req_ready SHALL be combinational: req_ready = issue mask when hold=0 and at least one req_valid is high; otherwise all zero.
REQ-017 At the clock edge after a cycle with a nonzero mask: write_reg_0_valid=1, write_reg_0_index=winner index, rd_index=winner index, and the internal stage-0 mask=issue mask; otherwise write_reg_0_valid=0, while the index outputs and mask hold their previous values.
REQ-018 Mask pipeline: stage-0 mask to stage-1 to stage-2, one register per cycle; arbiter_result = stage-2 mask ANDed with stage-2 valid, so it is nonzero exactly 2 cycles after write_reg_0_valid.
REQ-019 Pipeline stages SHALL shift every cycle, regardless of hold; hold only inserts bubbles at stage 0.
REQ-020 rr_ptr SHALL update to (winner+1) mod NUM_MUL on every issue, and stay unchanged otherwise.
REQ-021 Wrap-around: with rr_ptr=NUM_MUL-1, the search order SHALL be NUM_MUL-1, 0, 1, ...
REQ-022 Lanes not in the mask SHALL see req_ready=0 and must hold valid/index stable; no starvation, because the winner rotates.
REQ-023 busy = OR of stage-0, stage-1 and stage-2 valid.
REQ-024 hold rising in the same cycle as valid requests: no transfer and no issue; the outputs from the previous issue continue down the pipeline.

Reset
REQ-025 While reset=0 at a clock edge, the block SHALL clear:
- write_reg_0_valid, write_reg_0_index, rd_index and rr_ptr to 0
- all stage valids and stage masks to 0
- arbiter_result and busy to 0
REQ-026 During reset, req_ready SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight issues; no write mask is produced for them afterward.

Configuration
REQ-028 Macro XOR_SCHED_COALESCE_EN: when defined, the mask follows REQ-015; when undefined, the mask contains the winner only, and matching lanes wait for later rounds.

Verification
REQ-029 Scenario 1: NUM_MUL=4, reset released, lane 2 valid with idx 0x05A, hold=0 -> req_ready=0100 that cycle; write_reg_0_valid=1 and index 0x05A next cycle; arbiter_result=0100 two cycles later; rr_ptr=3.
REQ-030 Scenario 2: lanes 0 and 3 at idx 0x010, lane 1 at idx 0x020, rr_ptr=0 -> first issue mask 1001 (COALESCE_EN) then mask 0010; without the macro, the masks are 0001, 0010, 1000.
REQ-031 Scenario 3: all four lanes valid with distinct indices, continuously -> grant order 0,1,2,3,0; each lane is served once per 4 issues.
REQ-032 Scenario 4: rr_ptr=3, lanes 0 and 3 valid, different idx -> lane 3 wins first, then lane 0 (wrap).
REQ-033 Scenario 5: hold=1 for 3 cycles with lane 1 valid -> req_ready=0000, no new issue; an issue made before hold still gives arbiter_result 2 cycles later; issue resumes the cycle hold drops.
REQ-034 Scenario 6: reset=0 one cycle after an issue -> arbiter_result stays 0000 and busy=0 from the next edge.
